// File: rtl/frog_move_ctrl.sv
// frog_move_ctrl: key front end for the Frogger LED row.
// Each key is synchronized, debounced, and turned into one move request per press.
// The two key requests are then resolved against each other and against the row's
// lightOn vector, and the result is registered onto L / R / blocked.
// Optional feature: define FROG_AUTOREPEAT_EN to add auto-repeat while a key is held.

// One key lane: 2-flop synchronizer, debouncer, and press FSM.
module frog_key_lane #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic db,
    output logic req
);
    typedef enum logic [1:0] {IDLE, ARMED, HELD} st_t;

    logic [1:0]  sync;
    logic [15:0] cnt;
    st_t         st, st_nx;
    logic        rep_hit;

    // Out-of-range parameters are rejected when the design is elaborated.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 ||
        REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_bad_cfg
        $error("frog_key_lane: DEBOUNCE_CYCLES or REPEAT_CYCLES out of range");
    end

    // Two-flop synchronizer for the asynchronous key.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync <= 2'b00;
        else        sync <= {sync[0], key};
    end

    // Debouncer: accept a new level only after it has held DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db  <= 1'b0;
            cnt <= '0;
        end else if (sync[1] == db) begin
            cnt <= '0;
        end else if (cnt == 16'(DEBOUNCE_CYCLES - 1)) begin
            db  <= sync[1];
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

`ifdef FROG_AUTOREPEAT_EN
    logic [15:0] rcnt;

    // rcnt counts cycles since the last issued request while the key stays down,
    // so a hit at REPEAT_CYCLES-1 lands each repeat exactly REPEAT_CYCLES after the previous pulse.
    assign rep_hit = (st == HELD) && db && (rcnt == 16'(REPEAT_CYCLES - 1));

    // Repeat counter: runs through ARMED/HELD, restarts on each repeat, clears when the key goes idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                           rcnt <= '0;
        else if (st == IDLE || st_nx == IDLE) rcnt <= '0;
        else if (rep_hit)                     rcnt <= '0;
        else                                  rcnt <= rcnt + 16'd1;
    end
`else
    assign rep_hit = 1'b0;
`endif

    // Press FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) st <= IDLE;
        else        st <= st_nx;
    end

    // Press FSM next state; a request is raised on the debounced rising edge (and on repeats).
    always_comb begin
        st_nx = st;
        req   = 1'b0;
        case (st)
            IDLE:    if (db) begin
                         st_nx = ARMED;
                         req   = 1'b1;
                     end
            ARMED:   st_nx = db ? HELD : IDLE;
            HELD:    if (!db)         st_nx = IDLE;
                     else if (rep_hit) req  = 1'b1;
            default: st_nx = IDLE;
        endcase
    end
endmodule

// Top: two key lanes plus request resolution against the row.
module frog_move_ctrl #(
    parameter int N               = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         keyL,
    input  logic         keyR,
    input  logic [N-1:0] rowLights,
    output logic         L,
    output logic         R,
    output logic         blocked
);
    localparam int NUM_KEYS = 2;   // lane 1 = left, lane 0 = right

    logic [NUM_KEYS-1:0] keys, db, req;
    logic                mv_l, mv_r, blk;

    assign keys = {keyL, keyR};

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_lane
        frog_key_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_lane (
            .clk  (clk),
            .reset(reset),
            .key  (keys[k]),
            .db   (db[k]),
            .req  (req[k])
        );
    end

    // Resolve requests: any conflict, row edge, or missing frog turns the move into a blocked pulse.
    always_comb begin
        mv_l = 1'b0;
        mv_r = 1'b0;
        blk  = 1'b0;
        if (req[1] && req[0])         blk = 1'b1;
        else if (req[1] || req[0]) begin
            if (rowLights == '0)      blk = 1'b1;
            else if (req[1]) begin
                if (db[0] || rowLights[N-1]) blk  = 1'b1;
                else                         mv_l = 1'b1;
            end else begin
                if (db[1] || rowLights[0])   blk  = 1'b1;
                else                         mv_r = 1'b1;
            end
        end
    end

    // Register the resolved result so every pulse is exactly one clean cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            L       <= 1'b0;
            R       <= 1'b0;
            blocked <= 1'b0;
        end else begin
            L       <= mv_l;
            R       <= mv_r;
            blocked <= blk;
        end
    end
endmodule
